// File: rtl/udp_tx_arb_pkg.sv
// Shared types and constants for the UDP transmit arbiter: FSM encoding,
// requester indices and the default length/timeout limits.
package udp_tx_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_FD  = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_e;

  localparam int unsigned NUM_REQ = 3;

  localparam logic [1:0] REQ_ADC  = 2'd0;
  localparam logic [1:0] REQ_CMD  = 2'd1;
  localparam logic [1:0] REQ_STAT = 2'd2;

  localparam logic [11:0] DEF_MAX_LEN = 12'd1472;
  localparam logic [15:0] DEF_TIMEOUT = 16'd50000;

  // Round-robin successor over the three requesters (2 wraps to 0).
  function automatic logic [1:0] next_idx(input logic [1:0] idx);
    return (idx >= REQ_STAT) ? REQ_ADC : idx + 2'd1;
  endfunction

  function automatic logic [2:0] idx_to_onehot(input logic [1:0] idx);
    logic [2:0] oh;
    oh = 3'b000;
    case (idx)
      REQ_CMD:  oh = 3'b010;
      REQ_STAT: oh = 3'b100;
      default:  oh = 3'b001;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/udp_tx_arb_rr_pick.sv
// Combinational round-robin picker: searches the three request lines starting
// one past the last winner and reports the first one found.
module rr_pick
  import udp_tx_arb_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic       valid,
  output logic [1:0] winner
);

  logic [1:0] cand;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    valid  = 1'b0;
    winner = REQ_ADC;
    cand   = next_idx(ptr);
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!valid && req[cand]) begin
        valid  = 1'b1;
        winner = cand;
      end
      cand = next_idx(cand);
    end
  end

endmodule

// File: rtl/udp_tx_arb.sv
// Arbitrates three UDP payload sources onto a single MAC transmitter using a
// fs/fd handshake, with length screening and a bounded wait for fd.
module udp_tx_arb
  import udp_tx_arb_pkg::*;
#(
  parameter logic [15:0] TIMEOUT = DEF_TIMEOUT,
  parameter logic [11:0] MAX_LEN = DEF_MAX_LEN
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [35:0] req_len,
  output logic [2:0]  gnt,
  output logic [2:0]  done,
  output logic [1:0]  sel,
  output logic        fs_udp_tx,
  input  logic        fd_udp_tx,
  output logic [11:0] udp_tx_len,
  output logic        busy,
  output logic        err_to,
  output logic        err_len,
  output logic [15:0] tx_cnt
);

  state_e      state_q, state_d;
  logic [2:0]  gnt_q, gnt_d;
  logic [2:0]  done_q, done_d;
  logic [1:0]  sel_q, sel_d;
  logic [1:0]  ptr_q, ptr_d;
  logic        fs_q, fs_d;
  logic [11:0] len_q, len_d;
  logic        err_to_q, err_to_d;
  logic        err_len_q, err_len_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [15:0] to_cnt_q, to_cnt_d;
  logic        timed_out_q, timed_out_d;

  logic        pick_valid;
  logic [1:0]  pick_idx;
  logic [11:0] win_len;
  logic        len_bad;

  rr_pick u_rr_pick (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (pick_valid),
    .winner (pick_idx)
  );

  always_comb begin
    case (pick_idx)
      REQ_CMD:  win_len = req_len[23:12];
      REQ_STAT: win_len = req_len[35:24];
      default:  win_len = req_len[11:0];
    endcase
  end

  assign len_bad = (win_len == 12'd0) || (win_len > MAX_LEN);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    fs_d        = fs_q;
    len_d       = len_q;
    tx_cnt_d    = tx_cnt_q;
    to_cnt_d    = to_cnt_q;
    timed_out_d = timed_out_q;
    done_d      = 3'b000;
    err_to_d    = 1'b0;
    err_len_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          ptr_d = pick_idx;
          if (len_bad) begin
            // Rejected lengths complete immediately without touching the MAC.
            done_d    = idx_to_onehot(pick_idx);
            err_len_d = 1'b1;
          end else begin
            gnt_d       = idx_to_onehot(pick_idx);
            sel_d       = pick_idx;
            len_d       = win_len;
            fs_d        = 1'b1;
            to_cnt_d    = 16'd0;
            timed_out_d = 1'b0;
            state_d     = ST_WAIT_FD;
          end
        end
      end

      ST_WAIT_FD: begin
        to_cnt_d = to_cnt_q + 16'd1;
        if (fd_udp_tx) begin
          fs_d    = 1'b0;
          state_d = ST_WAIT_REL;
        end else if (to_cnt_q == TIMEOUT - 16'd1) begin
          fs_d        = 1'b0;
          err_to_d    = 1'b1;
          timed_out_d = 1'b1;
          state_d     = ST_WAIT_REL;
        end
      end

      ST_WAIT_REL: begin
        if (!fd_udp_tx) begin
          done_d  = gnt_q;
          gnt_d   = 3'b000;
          state_d = ST_IDLE;
          if (!timed_out_q) tx_cnt_d = tx_cnt_q + 16'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
        gnt_d   = 3'b000;
        fs_d    = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= 3'b000;
      done_q      <= 3'b000;
      sel_q       <= 2'd0;
      ptr_q       <= REQ_STAT;
      fs_q        <= 1'b0;
      len_q       <= 12'd0;
      err_to_q    <= 1'b0;
      err_len_q   <= 1'b0;
      tx_cnt_q    <= 16'd0;
      to_cnt_q    <= 16'd0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      fs_q        <= fs_d;
      len_q       <= len_d;
      err_to_q    <= err_to_d;
      err_len_q   <= err_len_d;
      tx_cnt_q    <= tx_cnt_d;
      to_cnt_q    <= to_cnt_d;
      timed_out_q <= timed_out_d;
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign sel        = sel_q;
  assign fs_udp_tx  = fs_q;
  assign udp_tx_len = len_q;
  assign busy       = (state_q != ST_IDLE);
  assign err_to     = err_to_q;
  assign err_len    = err_len_q;
  assign tx_cnt     = tx_cnt_q;

endmodule

// File: tb/tb_udp_tx_arb.sv
// Scoreboard bench for udp_tx_arb: stimulus pushes expected grants/completions,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_udp_tx_arb;

  typedef struct {
    logic [2:0]  gnt;
    logic [1:0]  sel;
    logic [11:0] len;
    int          fs_cycles;
  } grant_t;

  typedef struct {
    logic [2:0]  done;
    logic        err_len;
    int          err_to_n;
    logic [15:0] tx_cnt;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req = 3'b000;
  logic [35:0] req_len = 36'd0;
  logic        fd_udp_tx = 1'b0;
  logic [2:0]  gnt;
  logic [2:0]  done;
  logic [1:0]  sel;
  logic        fs_udp_tx;
  logic [11:0] udp_tx_len;
  logic        busy;
  logic        err_to;
  logic        err_len;
  logic [15:0] tx_cnt;

  int checks = 0;
  int failures = 0;
  int grants_seen = 0;
  bit mac_on = 1'b0;
  int fd_delay = 5;

  grant_t exp_grants[$];
  done_t  exp_dones[$];

  udp_tx_arb #(
    .TIMEOUT (16'd20),
    .MAX_LEN (12'd1472)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_len    (req_len),
    .gnt        (gnt),
    .done       (done),
    .sel        (sel),
    .fs_udp_tx  (fs_udp_tx),
    .fd_udp_tx  (fd_udp_tx),
    .udp_tx_len (udp_tx_len),
    .busy       (busy),
    .err_to     (err_to),
    .err_len    (err_len),
    .tx_cnt     (tx_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic push_grant(input logic [2:0] g, input logic [1:0] s, input logic [11:0] l,
                            input int fsc);
    grant_t e;
    e.gnt = g; e.sel = s; e.len = l; e.fs_cycles = fsc;
    exp_grants.push_back(e);
  endtask

  task automatic push_done(input logic [2:0] d, input logic el, input int et, input logic [15:0] tc);
    done_t e;
    e.done = d; e.err_len = el; e.err_to_n = et; e.tx_cnt = tc;
    exp_dones.push_back(e);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_grants.size() != 0 || exp_dones.size() != 0 || busy !== 1'b0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_drain"}, 32'(n < budget), 32'd1);
  endtask

  task automatic wait_grants(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (grants_seen < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check({name, "_grant_wait"}, 32'(n < budget), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // MAC model: raises fd fd_delay cycles into fs, drops it once fs falls.
  initial begin
    int mac_cnt;
    mac_cnt = 0;
    forever begin
      @(negedge clk);
      if (fs_udp_tx === 1'b0) begin
        fd_udp_tx = 1'b0;
        mac_cnt   = 0;
      end else if (mac_on) begin
        mac_cnt++;
        if (mac_cnt >= fd_delay) fd_udp_tx = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic [2:0] prev_gnt;
    logic       prev_busy;
    logic       prev_fs;
    int         fs_run;
    int         cur_fs_exp;
    int         to_seen;
    logic [1:0] gidx;
    grant_t     eg;
    done_t      ed;
    prev_gnt = 3'b000; prev_busy = 1'b0; prev_fs = 1'b0;
    fs_run = 0; cur_fs_exp = 0; to_seen = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        fs_run = 0; cur_fs_exp = 0; to_seen = 0;
      end else begin
        gidx = (gnt == 3'b010) ? 2'd1 : (gnt == 3'b100) ? 2'd2 : 2'd0;
        check("invariant_gnt_sel_fs",
              32'(($countones(gnt) <= 1) && (gnt == 3'b000 || sel == gidx) &&
                  (!fs_udp_tx || gnt != 3'b000)), 32'd1);

        if (gnt != 3'b000 && prev_gnt == 3'b000) begin
          grants_seen++;
          if (exp_grants.size() == 0) begin
            check("unexpected_grant", 32'(gnt), 32'd0);
          end else begin
            eg = exp_grants.pop_front();
            check("grant_gnt", 32'(gnt), 32'(eg.gnt));
            check("grant_sel", 32'(sel), 32'(eg.sel));
            check("grant_len", 32'(udp_tx_len), 32'(eg.len));
            check("grant_fs", 32'(fs_udp_tx), 32'd1);
            check("grant_idle_gap", 32'(prev_busy), 32'd0);
            cur_fs_exp = eg.fs_cycles;
          end
        end

        if (fs_udp_tx) begin
          fs_run++;
        end else if (prev_fs) begin
          if (cur_fs_exp != 0) check("fs_high_cycles", 32'(fs_run), 32'(cur_fs_exp));
          fs_run = 0;
        end

        if (err_to) to_seen++;

        if (done != 3'b000) begin
          if (exp_dones.size() == 0) begin
            check("unexpected_done", 32'(done), 32'd0);
          end else begin
            ed = exp_dones.pop_front();
            check("done_vec", 32'(done), 32'(ed.done));
            check("done_err_len", 32'(err_len), 32'(ed.err_len));
            check("done_err_to_pulses", 32'(to_seen), 32'(ed.err_to_n));
            check("done_tx_cnt", 32'(tx_cnt), 32'(ed.tx_cnt));
            check("done_fs_low", 32'(fs_udp_tx), 32'd0);
          end
          to_seen = 0;
        end else if (err_len) begin
          check("err_len_without_done", 32'(err_len), 32'd0);
        end
      end
      prev_gnt  = gnt;
      prev_busy = busy;
      prev_fs   = fs_udp_tx;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // Stimulus.
  initial begin
    int g0;
    do_reset();
    @(negedge clk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_fs", 32'(fs_udp_tx), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_len", 32'(udp_tx_len), 32'd0);
    check("rst_tx_cnt", 32'(tx_cnt), 32'd0);
    check("rst_errs", 32'({err_to, err_len}), 32'd0);

    // Single ADC transfer, fd after 5 cycles; length change after grant ignored.
    mac_on = 1'b1; fd_delay = 5;
    push_grant(3'b001, 2'd0, 12'd100, 0);
    push_done(3'b001, 1'b0, 0, 16'd1);
    req_len[11:0] = 12'd100;
    req = 3'b001;
    @(negedge clk);
    check("latency_gnt", 32'(gnt), 32'h1);
    check("latency_fs", 32'(fs_udp_tx), 32'd1);
    req = 3'b000;
    req_len[11:0] = 12'd200;
    repeat (2) @(negedge clk);
    check("latched_len", 32'(udp_tx_len), 32'd100);
    check("busy_in_xfer", 32'(busy), 32'd1);
    wait_idle("single", 100);
    check("single_tx_cnt", 32'(tx_cnt), 32'd1);

    // All three requesting: round-robin 0,1,2,0 from a fresh pointer.
    do_reset();
    @(negedge clk);
    fd_delay = 2;
    push_grant(3'b001, 2'd0, 12'd64, 0);
    push_grant(3'b010, 2'd1, 12'd64, 0);
    push_grant(3'b100, 2'd2, 12'd64, 0);
    push_grant(3'b001, 2'd0, 12'd64, 0);
    push_done(3'b001, 1'b0, 0, 16'd1);
    push_done(3'b010, 1'b0, 0, 16'd2);
    push_done(3'b100, 1'b0, 0, 16'd3);
    push_done(3'b001, 1'b0, 0, 16'd4);
    req_len = {12'd64, 12'd64, 12'd64};
    g0 = grants_seen;
    req = 3'b111;
    wait_grants("rr", g0 + 4, 200);
    req = 3'b000;
    wait_idle("rr", 200);

    // Bad lengths on requester 1: zero, then above MAX_LEN.
    push_done(3'b010, 1'b1, 0, 16'd4);
    req_len[23:12] = 12'd0;
    req = 3'b010;
    @(negedge clk);
    req = 3'b000;
    repeat (2) @(negedge clk);
    push_done(3'b010, 1'b1, 0, 16'd4);
    req_len[23:12] = 12'd1500;
    req = 3'b010;
    @(negedge clk);
    req = 3'b000;
    repeat (2) @(negedge clk);
    check("badlen_fs", 32'(fs_udp_tx), 32'd0);
    wait_idle("badlen", 20);
    check("badlen_tx_cnt", 32'(tx_cnt), 32'd4);

    // fd never returns: timeout after 20 cycles, then a normal transfer.
    mac_on = 1'b0;
    push_grant(3'b001, 2'd0, 12'd300, 20);
    push_done(3'b001, 1'b0, 1, 16'd4);
    req_len[11:0] = 12'd300;
    g0 = grants_seen;
    req = 3'b001;
    wait_grants("timeout", g0 + 1, 10);
    req = 3'b000;
    wait_idle("timeout", 100);
    mac_on = 1'b1; fd_delay = 3;
    push_grant(3'b100, 2'd2, 12'd64, 0);
    push_done(3'b100, 1'b0, 0, 16'd5);
    req_len[35:24] = 12'd64;
    g0 = grants_seen;
    req = 3'b100;
    wait_grants("post_to", g0 + 1, 10);
    req = 3'b000;
    wait_idle("post_to", 100);

    // Reset while waiting for fd, then requester 0 beats 2.
    mac_on = 1'b0;
    push_grant(3'b100, 2'd2, 12'd64, 0);
    g0 = grants_seen;
    req = 3'b100;
    wait_grants("midrst", g0 + 1, 10);
    req = 3'b000;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_fs", 32'(fs_udp_tx), 32'd0);
    check("midrst_gnt", 32'(gnt), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    mac_on = 1'b1; fd_delay = 2;
    push_grant(3'b001, 2'd0, 12'd64, 0);
    push_grant(3'b100, 2'd2, 12'd64, 0);
    push_done(3'b001, 1'b0, 0, 16'd1);
    push_done(3'b100, 1'b0, 0, 16'd2);
    req_len = {12'd64, 12'd64, 12'd64};
    g0 = grants_seen;
    req = 3'b101;
    wait_grants("prio0", g0 + 1, 10);
    req = 3'b100;
    wait_grants("prio2", g0 + 2, 50);
    req = 3'b000;
    wait_idle("prio", 100);

    repeat (3) @(negedge clk);
    check("queues_empty", 32'(exp_grants.size() + exp_dones.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/udp_tx_arb.md
UDP_TX_ARB -- requirements
Module: udp_tx_arb

Interface
REQ-001 Parameter TIMEOUT, default 16'd50000, SHALL set the max cycles to wait for fd_udp_tx after fs_udp_tx rises.
REQ-002 Parameter MAX_LEN, default 12'd1472, SHALL set the largest accepted UDP payload length in bytes.
REQ-003 clk  in  1  sole clock (sys_clk domain); one clock; reset is synchronous and active-high.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 req  in  3  per-requester transmit request level (0 = ADC data, 1 = command reply, 2 = status).
REQ-006 req_len  in  36  per-requester payload length, 12 bits each, requester i at bits [12i+11:12i].
REQ-007 gnt  out  3  one-hot grant, held for the whole transaction.
REQ-008 done  out  3  one-cycle completion pulse to the granted requester.
REQ-009 sel  out  2  binary index of the granted requester, for the tx datapath mux.
REQ-010 fs_udp_tx  out  1  start to MAC UDP transmitter.
REQ-011 fd_udp_tx  in  1  done from MAC UDP transmitter.
REQ-012 udp_tx_len  out  12  latched length of the granted request.
REQ-013 busy  out  1  high in every state except IDLE.
REQ-014 err_to  out  1  one-cycle pulse on fd timeout.
REQ-015 err_len  out  1  one-cycle pulse on a rejected length.
REQ-016 tx_cnt  out  16  count of successfully completed transfers.

Function
REQ-017 States: IDLE, WAIT_FD, WAIT_REL. No other state shall be reachable.
REQ-018 IDLE: if any req is high, the block picks a winner round-robin, starting the search at (last winner + 1) mod 3.
REQ-019 On the edge after a request is seen in IDLE, gnt, sel and udp_tx_len are updated and fs_udp_tx rises together (1-cycle latency); the state moves to WAIT_FD; the last-winner pointer is updated.
REQ-020 If the winner's len is 0 or exceeds MAX_LEN, the block asserts no fs_udp_tx; it pulses done[i] for one cycle, pulses err_len on the same cycle, updates the pointer and stays in IDLE.
REQ-021 WAIT_FD: fs_udp_tx held high; a 16-bit counter increments each cycle.
REQ-022 WAIT_FD, fd_udp_tx sampled high: fs_udp_tx drops the next cycle and the state moves to WAIT_REL.
REQ-023 WAIT_FD, counter reaches TIMEOUT-1 without fd_udp_tx: fs_udp_tx drops, err_to pulses one cycle, the state moves to WAIT_REL, and tx_cnt does not increment.
REQ-024 WAIT_REL, fd_udp_tx sampled low: done[i] pulses one cycle, gnt clears on the same edge, and the state moves to IDLE; tx_cnt increments only if the transfer was not timed out.
REQ-025 After a transfer returns to IDLE, at least one full IDLE cycle elapses before the next grant.
REQ-026 A requester dropping req or changing req_len during WAIT_FD or WAIT_REL has no effect; the latched values are used.
REQ-027 tx_cnt wraps from 16'hFFFF to 0.
REQ-028 fd_udp_tx high while in IDLE is ignored.
REQ-029 gnt is always zero or one-hot; sel equals the index of the set gnt bit, and holds its last value when gnt is 0.

Reset
REQ-030 Reset values: state IDLE; gnt, done, fs_udp_tx, busy, err_to, err_len = 0; sel, udp_tx_len, tx_cnt and the timeout counter = 0; last-winner pointer = 2, so requester 0 wins first.
REQ-031 Reset mid-transaction returns the block to IDLE on the next edge with fs_udp_tx low and no done pulse.

Structure
REQ-032 The shared package holds: state encoding, requester index constants (REQ_ADC = 0, REQ_CMD = 1, REQ_STAT = 2), the default MAX_LEN and the default TIMEOUT.
REQ-033 One sub-module, rr_pick, is purely combinational: inputs are the 3-bit req and the 2-bit pointer; outputs are a valid flag and a 2-bit winner.

Verification
REQ-034 req = 3'b001, len0 = 100, fd returns 5 cycles after fs -> gnt = 001 and fs high 1 cycle after req; udp_tx_len = 100; done[0] one pulse; tx_cnt = 1.
REQ-035 req = 3'b111 held, all len = 64, fast fd -> grant order 0, 1, 2, 0; each grant followed by at least 1 idle cycle.
REQ-036 req = 3'b010, len1 = 0, then len1 = 1500 -> fs never rises; done[1] and err_len pulse for each; tx_cnt unchanged.
REQ-037 TIMEOUT = 20, fd held low -> fs drops after 20 cycles; err_to one pulse; done[0] pulse; tx_cnt unchanged; next request is served normally.
REQ-038 Reset asserted during WAIT_FD with req = 3'b100 -> next cycle fs = 0, gnt = 0, no done pulse; after release, requester 0 has priority over 2 when both request.
